work_dispatch: RTL and testbench
================================

# work_dispatch

Round-robin work scheduler between the work-item FIFO (`fifo_sync`, 256-bit entries) and an array of hashing cores. It pops one work item at a time from the FIFO's read side and hands it to the next idle core with a one-cycle start pulse. It then waits for that core to acknowledge by dropping its idle flag. It also counts dispatches, flushes the FIFO on request, and flags cores that fail to acknowledge.

## Interface

Parameters:
- DATA_WIDTH, 256, work-item width; equals FIFO data width
- NUM_CORES, 4, number of hashing cores (2..16)
- CORE_IDX_W, 2, width of core index; ceil(log2(NUM_CORES))
- ACK_TIMEOUT, 15, cycles in WAIT before declaring acknowledge failure (1..255)

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- enable  in  1  allow dispatching
- flush  in  1  drain and discard FIFO contents
- err_clr  in  1  clears ack_err
- fifo_empty  in  1  FIFO empty flag
- fifo_data  in  DATA_WIDTH  FIFO head word (valid while !fifo_empty)
- fifo_re_en  out  1  FIFO pop strobe
- core_idle  in  NUM_CORES  per-core idle flag
- core_start  out  NUM_CORES  per-core start pulse, one-hot or zero
- core_data  out  DATA_WIDTH  work item for the started core
- grant_idx  out  CORE_IDX_W  index of last granted core
- busy  out  1  high when state != IDLE
- dispatch_count  out  32  number of items dispatched, wraps at 2^32
- ack_err  out  1  sticky acknowledge-timeout flag

## Operation

- States: IDLE, WAIT.
- Eligible set: core_idle bits. Pick: the first eligible index found scanning rr_ptr, rr_ptr+1, … with wrap at NUM_CORES (modulo, not power-of-2 masking).
- IDLE with flush=1:
  - fifo_re_en = !fifo_empty; the item is discarded.
  - No start, no count change, state stays IDLE.
  - flush has priority over enable.
- IDLE with flush=0, enable=1, !fifo_empty, eligible set non-empty:
  - fifo_re_en=1 (combinational, this cycle).
  - At the clock edge: core_data<=fifo_data, grant_idx<=pick, core_start[pick]<=1, dispatch_count+=1, timer<=0, state<=WAIT.
- Otherwise in IDLE: fifo_re_en=0; all registers hold.
- In WAIT:
  - core_start is forced to 0 (pulse is exactly one cycle); timer increments each cycle.
  - If core_idle[grant_idx]==0: state<=IDLE, rr_ptr<=(grant_idx+1) mod NUM_CORES.
  - Else if timer==ACK_TIMEOUT-1: ack_err<=1, state<=IDLE, rr_ptr advanced the same way.
  - flush and enable are ignored while in WAIT.
- core_data and grant_idx hold their values until the next dispatch.
- ack_err set takes priority over err_clr in the same cycle.
- fifo_re_en is never asserted while fifo_empty=1, and never asserted in WAIT.

## Timing

- Reset values: state IDLE, rr_ptr 0, core_start 0, core_data 0, grant_idx 0, busy 0, dispatch_count 0, ack_err 0, timer 0. fifo_re_en is 0 in reset (IDLE with no pop).
- Reset is asynchronous: asserting it mid-WAIT drops core_start and busy immediately.
- Pop-to-start latency: item popped in cycle T; core_data valid and core_start high in cycle T+1; busy high from T+1.
- Earliest acknowledge is cycle T+1: core_idle low in T+1 returns to IDLE at T+2.
- Dispatch rate: at most one item per 2 cycles.
- Timeout: with no acknowledge, state returns to IDLE at T+1+ACK_TIMEOUT, and ack_err is high from that cycle.
- All inputs are sampled on the rising clk edge. fifo_re_en depends combinationally on state, enable, flush, fifo_empty and core_idle.

## Test plan

- After reset, FIFO holds 4 items A,B,C,D; all 4 cores idle; each core acknowledges 1 cycle after start → starts go to cores 0,1,2,3 in order with core_data A,B,C,D; dispatch_count=4; 4 pops total.
- rr_ptr=2, only cores 0 and 3 idle, one item → core 3 granted; next item → core 0 (wrap).
- Core never acknowledges, ACK_TIMEOUT=15 → ack_err rises 15 cycles after start pulse and busy falls; err_clr then clears ack_err; next item goes to the following core.
- flush=1 and enable=1 with 3 items → 3 consecutive pops, no core_start, dispatch_count unchanged.
- fifo_empty=1 or enable=0 or no idle core → fifo_re_en stays 0 for 50 cycles; state stays IDLE.
- resetn pulsed low in the cycle core_start is high → core_start, busy, dispatch_count and ack_err are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/work_dispatch.sv
// Round-robin dispatcher: pops work items from the FIFO and starts
// the next idle hashing core, then waits for its acknowledge.
module work_dispatch #(
    parameter int DATA_WIDTH  = 256,
    parameter int NUM_CORES   = 4,
    parameter int CORE_IDX_W  = 2,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  err_clr,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_re_en,
    input  logic [NUM_CORES-1:0]  core_idle,
    output logic [NUM_CORES-1:0]  core_start,
    output logic [DATA_WIDTH-1:0] core_data,
    output logic [CORE_IDX_W-1:0] grant_idx,
    output logic                  busy,
    output logic [31:0]           dispatch_count,
    output logic                  ack_err
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    localparam logic [CORE_IDX_W:0] NC = (CORE_IDX_W+1)'(NUM_CORES);
    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    state_t state, state_nxt;

    logic [CORE_IDX_W-1:0] rr_ptr;
    logic [7:0]            timer;

    logic [CORE_IDX_W-1:0] pick;
    logic                  found;
    logic [CORE_IDX_W:0]   cand;
    logic [CORE_IDX_W:0]   gnext;
    logic [CORE_IDX_W-1:0] rr_wrap;

    logic dispatch;
    logic wait_done;
    logic tmo;

    // Scan rr_ptr, rr_ptr+1, ... with modulo wrap for any core count
    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            cand = {1'b0, rr_ptr} + (CORE_IDX_W+1)'(i);
            if (cand >= NC)
                cand = cand - NC;
            if (!found && core_idle[cand[CORE_IDX_W-1:0]]) begin
                found = 1'b1;
                pick  = cand[CORE_IDX_W-1:0];
            end
        end
    end

    always_comb begin
        gnext = {1'b0, grant_idx} + (CORE_IDX_W+1)'(1);
        if (gnext >= NC)
            gnext = '0;
        rr_wrap = gnext[CORE_IDX_W-1:0];
    end

    always_comb begin
        state_nxt  = state;
        fifo_re_en = 1'b0;
        dispatch   = 1'b0;
        wait_done  = 1'b0;
        tmo        = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (flush) begin
                    fifo_re_en = !fifo_empty;
                end else if (enable && !fifo_empty && found) begin
                    fifo_re_en = 1'b1;
                    dispatch   = 1'b1;
                    state_nxt  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!core_idle[grant_idx]) begin
                    wait_done = 1'b1;
                    state_nxt = S_IDLE;
                end else if (timer == TMO_LAST) begin
                    tmo       = 1'b1;
                    wait_done = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
        endcase
    end

    assign busy = (state == S_WAIT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= S_IDLE;
            rr_ptr         <= '0;
            timer          <= '0;
            core_start     <= '0;
            core_data      <= '0;
            grant_idx      <= '0;
            dispatch_count <= '0;
            ack_err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            core_start <= '0;
            if (dispatch) begin
                core_data      <= fifo_data;
                grant_idx      <= pick;
                core_start     <= NUM_CORES'(1) << pick;
                dispatch_count <= dispatch_count + 32'd1;
                timer          <= '0;
            end else if (state == S_WAIT) begin
                timer <= timer + 8'd1;
            end
            if (wait_done)
                rr_ptr <= rr_wrap;
            // A timeout in the same cycle as err_clr keeps the flag set
            if (tmo)
                ack_err <= 1'b1;
            else if (err_clr)
                ack_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_work_dispatch.sv
// Scoreboard bench for work_dispatch: FIFO and core models driven
// from one thread, expected grants queued and matched on start pulses.
module tb_work_dispatch;

    localparam int DW = 256;
    localparam int NC = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          resetn;
    logic          enable;
    logic          flush;
    logic          err_clr;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_re_en;
    logic [NC-1:0] core_idle;
    logic [NC-1:0] core_start;
    logic [DW-1:0] core_data;
    logic [IW-1:0] grant_idx;
    logic          busy;
    logic [31:0]   dispatch_count;
    logic          ack_err;

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] fq[$];

    int checks = 0;
    int errors = 0;
    int pops = 0;
    int busy_seen = 0;
    bit saw_start;

    logic [NC-1:0] idle_en;
    logic [NC-1:0] ack_en;
    int            bcnt[NC];

    work_dispatch #(
        .DATA_WIDTH(DW),
        .NUM_CORES(NC),
        .CORE_IDX_W(IW),
        .ACK_TIMEOUT(15)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .enable(enable),
        .flush(flush),
        .err_clr(err_clr),
        .fifo_empty(fifo_empty),
        .fifo_data(fifo_data),
        .fifo_re_en(fifo_re_en),
        .core_idle(core_idle),
        .core_start(core_start),
        .core_data(core_data),
        .grant_idx(grant_idx),
        .busy(busy),
        .dispatch_count(dispatch_count),
        .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [DW-1:0] mk();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++)
            v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic fifo_refresh();
        fifo_empty = (fq.size() == 0);
        if (fq.size() > 0)
            fifo_data = fq[0];
        else
            fifo_data = '0;
    endtask

    task automatic core_refresh();
        for (int i = 0; i < NC; i++)
            core_idle[i] = idle_en[i] && (bcnt[i] == 0);
    endtask

    task automatic push_item(input logic [DW-1:0] d);
        fq.push_back(d);
        fifo_refresh();
    endtask

    task automatic expect_grant(input int idx, input logic [DW-1:0] d);
        exp_t e;
        e.idx  = idx;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // One clock: sample strobes at the edge, update models, then check
    task automatic tick();
        logic          re;
        logic [NC-1:0] st;
        logic [DW-1:0] d;
        exp_t          e;
        saw_start = 1'b0;
        @(posedge clk);
        re = fifo_re_en;
        st = core_start;
        #1;
        if (re) begin
            chk("pop_nonempty", {255'd0, fifo_empty}, '0);
            if (fq.size() > 0)
                d = fq.pop_front();
            pops++;
        end
        if (busy)
            busy_seen++;
        for (int i = 0; i < NC; i++) begin
            if (st[i] && ack_en[i])
                bcnt[i] = 3;
            else if (bcnt[i] > 0)
                bcnt[i]--;
        end
        fifo_refresh();
        core_refresh();
        @(negedge clk);
        if (core_start != '0) begin
            saw_start = 1'b1;
            if (exp_q.size() == 0) begin
                chk("unexpected_start", {252'd0, core_start}, '0);
            end else begin
                e = exp_q.pop_front();
                chk("start_onehot", {252'd0, core_start},
                    DW'(1) << e.idx);
                chk("core_data", core_data, e.data);
                chk("grant_idx", {254'd0, grant_idx}, DW'(e.idx));
            end
        end
    endtask

    task automatic run_until_done(input string tag, input int limit);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while ((exp_q.size() > 0 || fq.size() > 0 || busy) && k < limit);
        chk(tag, {255'd0, (k < limit)}, DW'(1));
    endtask

    task automatic wait_start(input string tag);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!saw_start && k < 20);
        chk(tag, {255'd0, saw_start}, DW'(1));
    endtask

    initial begin
        logic [DW-1:0] d[4];
        logic [DW-1:0] x;
        int            n;

        resetn  = 1'b0;
        enable  = 1'b0;
        flush   = 1'b0;
        err_clr = 1'b0;
        idle_en = '1;
        ack_en  = '1;
        for (int i = 0; i < NC; i++)
            bcnt[i] = 0;
        fifo_refresh();
        core_refresh();
        repeat (2) @(negedge clk);

        chk("rst_busy", {255'd0, busy}, '0);
        chk("rst_start", {252'd0, core_start}, '0);
        chk("rst_count", {224'd0, dispatch_count}, '0);
        chk("rst_ack_err", {255'd0, ack_err}, '0);
        chk("rst_grant", {254'd0, grant_idx}, '0);
        chk("rst_data", core_data, '0);
        chk("rst_re_en", {255'd0, fifo_re_en}, '0);
        resetn = 1'b1;

        // Four items, all cores idle: grants 0,1,2,3 in order
        pops = 0;
        for (int i = 0; i < 4; i++) begin
            d[i] = mk();
            push_item(d[i]);
            expect_grant(i, d[i]);
        end
        enable = 1'b1;
        run_until_done("t1_drain", 100);
        chk("t1_count", {224'd0, dispatch_count}, DW'(4));
        chk("t1_pops", DW'(pops), DW'(4));

        // Move rr_ptr to 2, then only cores 0 and 3 idle
        for (int i = 0; i < 2; i++) begin
            x = mk();
            push_item(x);
            expect_grant(i, x);
        end
        run_until_done("t2a_drain", 100);
        idle_en = 4'b1001;
        core_refresh();
        repeat (6) tick();
        x = mk();
        push_item(x);
        expect_grant(3, x);
        x = mk();
        push_item(x);
        expect_grant(0, x);
        run_until_done("t2b_drain", 100);
        chk("t2_count", {224'd0, dispatch_count}, DW'(8));

        // Core 1 never acknowledges: timeout after 15 cycles
        idle_en = '1;
        ack_en  = 4'b1101;
        core_refresh();
        repeat (6) tick();
        x = mk();
        push_item(x);
        expect_grant(1, x);
        wait_start("t3_start");
        n = 0;
        do begin
            tick();
            n++;
        end while (busy && n < 40);
        chk("t3_timeout_cycles", DW'(n), DW'(15));
        chk("t3_ack_err_set", {255'd0, ack_err}, DW'(1));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t3_ack_err_clr", {255'd0, ack_err}, '0);
        ack_en = '1;
        x = mk();
        push_item(x);
        expect_grant(2, x);
        run_until_done("t3_drain", 100);
        chk("t3_count", {224'd0, dispatch_count}, DW'(10));

        // Flush wins over enable: three back-to-back pops, no starts
        pops  = 0;
        flush = 1'b1;
        for (int i = 0; i < 3; i++)
            push_item(mk());
        repeat (3) tick();
        chk("t4_pops", DW'(pops), DW'(3));
        chk("t4_empty", {255'd0, fifo_empty}, DW'(1));
        flush = 1'b0;
        tick();
        chk("t4_count", {224'd0, dispatch_count}, DW'(10));

        // Idle holds: empty FIFO, enable low, no idle core
        pops      = 0;
        busy_seen = 0;
        repeat (50) tick();
        chk("t5_empty_pops", DW'(pops), '0);
        enable = 1'b0;
        x = mk();
        push_item(x);
        repeat (50) tick();
        chk("t5_disabled_pops", DW'(pops), '0);
        enable  = 1'b1;
        idle_en = '0;
        core_refresh();
        repeat (50) tick();
        chk("t5_noidle_pops", DW'(pops), '0);
        chk("t5_busy_seen", DW'(busy_seen), '0);
        idle_en = '1;
        core_refresh();
        expect_grant(3, x);
        run_until_done("t5_drain", 100);
        chk("t5_count", {224'd0, dispatch_count}, DW'(11));

        // Asynchronous reset during the start pulse
        x = mk();
        push_item(x);
        expect_grant(0, x);
        wait_start("t6_start");
        chk("t6_count_pre", {224'd0, dispatch_count}, DW'(12));
        #2;
        resetn = 1'b0;
        #1;
        chk("t6_start_rst", {252'd0, core_start}, '0);
        chk("t6_busy_rst", {255'd0, busy}, '0);
        chk("t6_count_rst", {224'd0, dispatch_count}, '0);
        chk("t6_ack_err_rst", {255'd0, ack_err}, '0);
        @(negedge clk);
        resetn = 1'b1;
        chk("t6_exp_drained", DW'(exp_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
